// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding,
// register-address width and the NOP instruction word.
package pipeline_hazard_ctrl_pkg;

   localparam int SIZE_ADDR_BR = 5;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator between the load in ID_EX and the
// source registers of the instruction in ID.
module hazard_detect #(
   parameter int SIZE_ADDR_BR = 5
) (
   input  logic [SIZE_ADDR_BR-1:0] id_rs,
   input  logic [SIZE_ADDR_BR-1:0] id_rt,
   input  logic                    id_uses_rt,
   input  logic                    id_jump,
   input  logic                    ex_mem_read,
   input  logic [SIZE_ADDR_BR-1:0] ex_rt,
   output logic                    load_use
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = (ex_rt == id_rs);
   assign rt_hit = id_uses_rt & (ex_rt == id_rt);

   // $zero is never a real producer; a jump in ID never consumes operands
   assign load_use = ex_mem_read & (ex_rt != '0) & ~id_jump & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline, with a data-memory
// wait watchdog and stall/flush performance counters.
//
//   state    | meaning
//   RUN      | normal issue; hazards resolved by priority each cycle
//   MEM_WAIT | data memory busy, pipeline frozen, watchdog counting
//   HALT     | watchdog expired, pipeline frozen until reset
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int SIZE_ADDR_BR = pipeline_hazard_ctrl_pkg::SIZE_ADDR_BR,
   parameter int CNT_W        = 32,
   parameter int MEM_TIMEOUT  = 64,
   parameter int TO_W         = 7
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SIZE_ADDR_BR-1:0] id_rs,
   input  logic [SIZE_ADDR_BR-1:0] id_rt,
   input  logic                    id_uses_rt,
   input  logic                    id_jump,
   input  logic                    ex_mem_read,
   input  logic [SIZE_ADDR_BR-1:0] ex_rt,
   input  logic                    mem_branch_taken,
   input  logic                    dmem_req,
   input  logic                    dmem_ready,
   output logic                    pc_write,
   output logic                    if_id_write,
   output logic                    if_id_flush,
   output logic                    id_ex_write,
   output logic                    id_ex_flush,
   output logic                    ex_mem_write,
   output logic                    ex_mem_flush,
   output logic                    mem_wb_flush,
   output logic                    halted,
   output logic [CNT_W-1:0]        stall_cnt,
   output logic [CNT_W-1:0]        flush_cnt
);

   hz_state_t       state_q, state_nxt;
   logic [TO_W-1:0] wait_q, wait_nxt, wait_inc;
   logic            load_use;
   logic            mem_stall;
   logic            run_eval;
   logic            stall_inc;
   logic            flush_inc;

   hazard_detect #(.SIZE_ADDR_BR(SIZE_ADDR_BR)) u_hazard_detect (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .id_jump     (id_jump),
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .load_use    (load_use)
   );

   assign mem_stall = dmem_req & ~dmem_ready;
   assign wait_inc  = wait_q + TO_W'(1);
   assign halted    = (state_q == HALT);

   always_comb begin
      state_nxt    = state_q;
      wait_nxt     = wait_q;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      run_eval     = 1'b0;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;

      unique case (state_q)
         RUN: begin
            if (mem_stall) begin
               {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
               mem_wb_flush = 1'b1;
               stall_inc    = 1'b1;
               wait_nxt     = TO_W'(1);
               state_nxt    = (MEM_TIMEOUT <= 1) ? HALT : MEM_WAIT;
            end else begin
               run_eval = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               run_eval  = 1'b1;
               wait_nxt  = '0;
               state_nxt = RUN;
            end else begin
               {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
               mem_wb_flush = 1'b1;
               stall_inc    = 1'b1;
               wait_nxt     = wait_inc;
               if (wait_inc >= TO_W'(MEM_TIMEOUT)) state_nxt = HALT;
            end
         end
         HALT: begin
            {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase

      // A taken branch squashes IF_ID/ID_EX/EX_MEM, so hazards there are moot
      if (run_eval) begin
         if (mem_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            flush_inc    = 1'b1;
         end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
         end else if (id_jump) begin
            if_id_flush = 1'b1;
            flush_inc   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RUN;
         wait_q    <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state_q <= state_nxt;
         wait_q  <= wait_nxt;
         if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule
